// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional per-requester grant and stall counters: define ALU_ARBITER_STATS_EN.
module alu_arbiter #(
    parameter int data_width = 32,
    parameter int op_width   = 4,
    parameter int flag_width = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [op_width-1:0]   req0_op,
    input  logic [data_width-1:0] req0_a,
    input  logic [data_width-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [op_width-1:0]   req1_op,
    input  logic [data_width-1:0] req1_a,
    input  logic [data_width-1:0] req1_b,
    output logic [op_width-1:0]   alu_op,
    output logic [data_width-1:0] alu_a,
    output logic [data_width-1:0] alu_b,
    input  logic [data_width-1:0] alu_r,
    input  logic [flag_width-1:0] alu_flag,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [data_width-1:0] rsp_r,
    output logic [flag_width-1:0] rsp_flag,
    input  logic                  rsp_ready
`ifdef ALU_ARBITER_STATS_EN
    ,
    output logic [15:0]           grant_cnt0,
    output logic [15:0]           grant_cnt1,
    output logic [15:0]           stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_grant;
    logic   grant_id;
    logic   grant0;
    logic   grant1;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || last_grant)) begin
                    grant0 = 1'b1;
                end else if (req1_valid) begin
                    grant1 = 1'b1;
                end
                if (grant0 || grant1) begin
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Gated with rst so every output reads 0 while reset is held.
    assign req0_ready = grant0 && rst;
    assign req1_ready = grant1 && rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_r      <= '0;
            rsp_flag   <= '0;
        end else begin
            state <= state_next;
            if (grant0) begin
                alu_op     <= req0_op;
                alu_a      <= req0_a;
                alu_b      <= req0_b;
                last_grant <= 1'b0;
                grant_id   <= 1'b0;
            end else if (grant1) begin
                alu_op     <= req1_op;
                alu_a      <= req1_a;
                alu_b      <= req1_b;
                last_grant <= 1'b1;
                grant_id   <= 1'b1;
            end
            if (state == CAPTURE) begin
                rsp_r     <= alu_r;
                rsp_flag  <= alu_flag;
                rsp_id    <= grant_id;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ARBITER_STATS_EN
    // Grant counters wrap; the stall counter saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt0 <= 16'd0;
            grant_cnt1 <= 16'd0;
            stall_cnt  <= 16'd0;
        end else begin
            if (grant0) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (grant1) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
            if (((req0_valid && !grant0) || (req1_valid && !grant1)) &&
                stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
